aes_ps_seq: RTL and testbench

- Sequencer for the 8-bit AES datapath's 4-byte parallel-to-serial column converter.
- Accepts 32-bit column words from the upstream word source (valid/ready handshake).
- Drives the converter's parallel-load strobe, parallel data and serial-in byte, and frames the resulting byte stream into 16-byte AES blocks for the downstream byte-serial stage.
- Guarantees the 4-cycle load/shift cadence the converter needs; the converter has no enable and shifts every clock.

---
 rtl/aes_pkg.sv | 12 +
 rtl/aes_ps_seq.sv | 73 +++++++
 tb/tb_aes_ps_seq.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared widths and types for the byte-serial AES datapath.
// Column words carry WORD_BYTES bytes, most significant byte first.
package aes_pkg;

    localparam int BYTE_W        = 8;
    localparam int WORD_BYTES    = 4;
    localparam int AES_BLK_WORDS = 4;

    typedef logic [BYTE_W-1:0]            aes_byte_t;
    typedef logic [WORD_BYTES*BYTE_W-1:0] aes_word_t;

endpackage

// File: rtl/aes_ps_seq.sv
// Load/shift sequencer for the 4-byte parallel-to-serial column converter.
// Frames the converter's byte stream into AES blocks for the serial stage.
module aes_ps_seq #(
    parameter int WORDS_PER_BLK = aes_pkg::AES_BLK_WORDS,
    parameter int BYTE_W        = aes_pkg::BYTE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                word_valid,
    input  logic [4*BYTE_W-1:0] word_data,
    output logic                word_ready,
    input  logic [BYTE_W-1:0]   sin_byte,
    input  logic                sink_ready,
    output logic                conv_pld,
    output logic [4*BYTE_W-1:0] conv_pdin,
    output logic [BYTE_W-1:0]   conv_din,
    output logic                byte_valid,
    output logic                byte_first,
    output logic                byte_last,
    output logic                blk_done,
    output logic                busy
);
    import aes_pkg::*;

    localparam int WC_W =
        (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WORDS_PER_BLK - 1);
    localparam logic [1:0]      IDX_LAST = 2'(WORD_BYTES - 1);

    logic [1:0]      sh_cnt;
    logic [WC_W-1:0] word_cnt;
    logic            accept;
    logic [1:0]      idx;
    logic            last_word;

    assign word_ready = sink_ready & (sh_cnt == 2'd0) & ~flush;
    assign accept     = word_valid & word_ready;
    assign idx        = accept ? 2'd0 : sh_cnt;
    assign last_word  = (word_cnt == WC_LAST);

    // The converter sees the load in the accept cycle itself.
    assign conv_pld  = accept;
    assign conv_pdin = word_data;
    assign conv_din  = sin_byte;

    assign byte_valid = accept | (sh_cnt != 2'd0);
    assign byte_first = accept & (word_cnt == '0);
    assign byte_last  = byte_valid & (idx == IDX_LAST) & last_word;
    assign busy       = (sh_cnt != 2'd0) | (word_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_cnt   <= 2'd0;
            word_cnt <= '0;
            blk_done <= 1'b0;
        end else if (flush) begin
            sh_cnt   <= 2'd0;
            word_cnt <= '0;
            blk_done <= 1'b0;
        end else begin
            blk_done <= byte_last;
            // A started word always runs its remaining bytes out.
            if (accept)
                sh_cnt <= 2'd1;
            else if (sh_cnt != 2'd0)
                sh_cnt <= sh_cnt + 2'd1;
            if (sh_cnt == IDX_LAST)
                word_cnt <= last_word ? '0 : word_cnt + WC_W'(1);
        end
    end

endmodule

// File: tb/tb_aes_ps_seq.sv
// Bench for aes_ps_seq with a behavioural column converter.
// Expected bytes are queued when driven and popped as they appear.
module tb_aes_ps_seq;

    localparam int WPB = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        word_ready;
    logic [7:0]  sin_byte = '0;
    logic        sink_ready = 1'b1;
    logic        conv_pld;
    logic [31:0] conv_pdin;
    logic [7:0]  conv_din;
    logic        byte_valid;
    logic        byte_first;
    logic        byte_last;
    logic        blk_done;
    logic        busy;

    logic [31:0] sr = '0;
    logic [7:0]  dout;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   wi = 0;
    int   n_sent = 0;
    int   n_pld = 0;
    logic prev_last = 1'b0;

    aes_ps_seq #(.WORDS_PER_BLK(WPB), .BYTE_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .word_valid(word_valid), .word_data(word_data),
        .word_ready(word_ready), .sin_byte(sin_byte),
        .sink_ready(sink_ready), .conv_pld(conv_pld),
        .conv_pdin(conv_pdin), .conv_din(conv_din),
        .byte_valid(byte_valid), .byte_first(byte_first),
        .byte_last(byte_last), .blk_done(blk_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Converter: load-through mux in the load cycle, shift every clock.
    assign dout = conv_pld ? conv_pdin[31:24] : sr[31:24];
    always @(posedge clk) begin
        sr <= conv_pld ? {conv_pdin[23:0], conv_din}
                       : {sr[23:0], conv_din};
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic nl;
        if (rst) begin
            prev_last = 1'b0;
        end else begin
            check("blk_done", 32'(blk_done), 32'(prev_last));
            nl = 1'b0;
            if (byte_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_byte", 32'(dout), 32'hx);
                end else begin
                    e = sb.pop_front();
                    check("dout", 32'(dout), 32'(e.data));
                    check("byte_first", 32'(byte_first), 32'(e.first));
                    check("byte_last", 32'(byte_last), 32'(e.last));
                    nl = e.last & ~flush;
                end
            end
            prev_last = nl;
            if (conv_pld) n_pld++;
        end
    end

    task automatic push_word(input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.data  = d[31-8*i -: 8];
            e.first = (wi == 0) && (i == 0);
            e.last  = (wi == WPB - 1) && (i == 3);
            sb.push_back(e);
        end
        wi = (wi + 1) % WPB;
    endtask

    // Leaves word_valid high; returns one cycle after the accept.
    task automatic send_word(input logic [31:0] d, output int acc_cyc,
                             output int waited);
        logic ok = 1'b0;
        acc_cyc = -1;
        waited = -1;
        push_word(d);
        word_valid = 1'b1;
        word_data = d;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (word_ready) begin
                check("pld_on_accept", 32'(conv_pld), 32'd1);
                check("pdin", conv_pdin, d);
                acc_cyc = cyc;
                waited = i;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        n_sent++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int a0, a1, w;
        int acc[4];
        logic [31:0] blk[4];
        blk[0] = 32'h00010203;
        blk[1] = 32'h04050607;
        blk[2] = 32'h08090A0B;
        blk[3] = 32'h0C0D0E0F;

        // Reset state
        @(negedge clk);
        check("rst_word_ready", 32'(word_ready), 32'd1);
        check("rst_pld", 32'(conv_pld), 32'd0);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_blk_done", 32'(blk_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        // Single word
        send_word(32'hA1B2C3D4, a0, w);
        check("single_wait", 32'(w), 32'd0);
        word_valid = 1'b0;
        idle(3);
        @(negedge clk);
        check("single_valid_after", 32'(byte_valid), 32'd0);
        check("single_busy_after", 32'(busy), 32'd1);
        check("single_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wi = 0;
        @(negedge clk);
        check("flush_idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Full block, back to back
        for (int k = 0; k < 4; k++) send_word(blk[k], acc[k], w);
        word_valid = 1'b0;
        for (int k = 1; k < 4; k++)
            check("b2b_spacing", 32'(acc[k] - acc[k-1]), 32'd4);
        idle(4);
        @(negedge clk);
        check("blk_busy_after", 32'(busy), 32'd0);
        check("blk_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;

        // Backpressure
        sink_ready = 1'b0;
        push_word(32'h5A6B7C8D);
        word_valid = 1'b1;
        word_data = 32'h5A6B7C8D;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready", 32'(word_ready), 32'd0);
            check("bp_pld", 32'(conv_pld), 32'd0);
            check("bp_valid", 32'(byte_valid), 32'd0);
            @(posedge clk); #1;
        end
        sink_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_same", 32'(conv_pld), 32'd1);
        n_sent++;
        @(posedge clk); #1;
        word_valid = 1'b0;
        sink_ready = 1'b0;
        idle(3);
        check("bp_sb_empty", 32'(sb.size()), 32'd0);
        sink_ready = 1'b1;

        // Flush at byte index 2 of word 1
        send_word(32'hDEADBEEF, a0, w);
        word_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        word_valid = 1'b1;
        word_data = 32'h01020304;
        @(negedge clk);
        check("flush_ready", 32'(word_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        word_valid = 1'b0;
        sb.delete();
        wi = 0;
        @(negedge clk);
        check("flush_valid", 32'(byte_valid), 32'd0);
        check("flush_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        send_word(32'h01020304, a0, w);
        word_valid = 1'b0;
        idle(4);

        // Async reset mid-word
        send_word(32'h99887766, a0, w);
        word_valid = 1'b0;
        #2;
        sb.delete();
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(byte_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_first", 32'(byte_first), 32'd0);
        check("arst_last", 32'(byte_last), 32'd0);
        check("arst_ready", 32'(word_ready), 32'd1);
        wi = 0;
        idle(2);
        rst = 1'b0;
        idle(4);
        check("arst_no_done", 32'(blk_done), 32'd0);

        // Serial tail
        push_word(32'hCAFEF00D);
        word_valid = 1'b1;
        word_data = 32'hCAFEF00D;
        sin_byte = 8'h11;
        @(negedge clk);
        check("tail_load", 32'(conv_pld), 32'd1);
        check("tail_din", 32'(conv_din), 32'h11);
        n_sent++;
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            word_valid = 1'b0;
            sin_byte = 8'(8'h11 * (k + 1));
            @(negedge clk);
            check("tail_din", 32'(conv_din), 32'(8'h11 * (k + 1)));
        end
        @(posedge clk); #1;
        sin_byte = 8'h55;
        @(negedge clk);
        check("tail_sr", sr, 32'h11223344);
        check("tail_dout", 32'(dout), 32'h11);
        @(posedge clk); #1;
        send_word(32'h13579BDF, a1, w);
        word_valid = 1'b0;
        idle(5);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("pld_count", 32'(n_pld), 32'(n_sent));
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
